// File: rtl/stack_pkg.sv
// Shared definitions for the LIFO stack.
// Holds the default width/depth and the request-decode helper used by
// param_stack to resolve which request wins in a given cycle.
package stack_pkg;

  localparam int STACK_WIDTH_DEF = 8;
  localparam int STACK_DEPTH_DEF = 32;

  // Winning request class for a cycle, in priority order.
  typedef enum logic [1:0] {
    OP_CLEAR    = 2'd0,  // flush, overrides everything
    OP_XCHG     = 2'd1,  // push and pop together: exchange or bypass
    OP_POP      = 2'd2,  // pop alone (tos ignored when popping)
    OP_PUSH_TOS = 2'd3   // push and/or tos, or idle
  } op_e;

  // Resolve the request priority: clear > push+pop > pop > push/tos.
  function automatic op_e decode_op(input logic clear, input logic push, input logic pop);
    op_e sel;
    if (clear) begin
      sel = OP_CLEAR;
    end else if (push && pop) begin
      sel = OP_XCHG;
    end else if (pop) begin
      sel = OP_POP;
    end else begin
      sel = OP_PUSH_TOS;
    end
    return sel;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// Stack storage: DEPTH x WIDTH array, one synchronous write port and one
// asynchronous read port. Intentionally not reset; only entries below the
// occupancy count are ever read.
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - combinational read data
module stack_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_stack.sv
// Parameterised LIFO stack with registered read data.
// Supports push, pop, top-of-stack peek, simultaneous push+pop exchange
// (bypass when empty) and a synchronous clear. Errors are reported as
// one-cycle overflow/underflow pulses; the occupancy count saturates.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   din, push, pop, tos  - data in and requests
//   clear                - synchronous flush, highest priority
//   dout, dout_valid     - registered read data and its one-cycle strobe
//   count, full, empty   - occupancy and its decodes
//   overflow, underflow  - one-cycle error pulses
module param_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH_DEF,
  parameter int DEPTH = STACK_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       din,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   tos,
  input  logic                   clear,
  output logic [WIDTH-1:0]       dout,
  output logic                   dout_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);

  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             is_full, is_empty;
  logic [PTR_W-1:0] top_idx;
  logic             wr_en;
  logic [PTR_W-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] rd_data;
  op_e              op;

  assign is_full  = (count_q == CNT_MAX);
  assign is_empty = (count_q == CNT_ZERO);
  // Top entry index; the wrapped value when empty is never used for a read.
  assign top_idx  = PTR_W'(count_q - CNT_ONE);
  assign op       = decode_op(clear, push, pop);

  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (top_idx),
    .rdata (rd_data)
  );

  // Next-state for count, read data, strobes and the storage write port.
  always_comb begin
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    overflow_d   = 1'b0;
    underflow_d  = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = count_q[PTR_W-1:0];
    wr_data      = din;
    case (op)
      OP_CLEAR: begin
        count_d = CNT_ZERO;
      end
      OP_XCHG: begin
        dout_valid_d = 1'b1;
        if (is_empty) begin
          // Bypass: nothing stored, the pushed word comes straight back.
          dout_d = din;
        end else begin
          // Exchange: return old top and overwrite it in place.
          dout_d  = rd_data;
          wr_en   = 1'b1;
          wr_addr = top_idx;
        end
      end
      OP_POP: begin
        if (is_empty) begin
          underflow_d = 1'b1;
        end else begin
          dout_d       = rd_data;
          dout_valid_d = 1'b1;
          count_d      = count_q - CNT_ONE;
        end
      end
      OP_PUSH_TOS: begin
        // Peek sees the pre-push top; the push then proceeds independently.
        if (tos) begin
          if (is_empty) begin
            underflow_d = 1'b1;
          end else begin
            dout_d       = rd_data;
            dout_valid_d = 1'b1;
          end
        end else begin
          dout_valid_d = 1'b0;
        end
        if (push) begin
          if (is_full) begin
            overflow_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            count_d = count_q + CNT_ONE;
          end
        end else begin
          wr_en = 1'b0;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= CNT_ZERO;
      dout_q       <= {WIDTH{1'b0}};
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign count      = count_q;
  assign full       = is_full;
  assign empty      = is_empty;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule
